// File: rtl/rename_nway_if.sv
// rename_nway_pkg / rename_nway_if
//
// Purpose: shared types for the rename stage and the interface bundling its
// decode, RAT, ROB, commit and dispatch signals.
//
// Interface signals (direction seen from the rename stage, modport slave):
//   flush               in   sync pipeline flush
//   decoded_insts       in   decode group, valid slots form a prefix
//   dec_accept          out  per-slot consume mask (prefix)
//   rat_rs1/2_addr      out  RAT read addresses
//   rat_rs1/2_data      in   async RAT read results
//   rat_write_ports     out  speculative rd->tag mappings
//   rob_alloc_req       out  per-slot ROB allocation request
//   rob_alloc_gnt       in   ROB grant (prefix of request)
//   rob_alloc_tags      in   allocated tags
//   commit_write_ports  in   commit data/tag/we used for bypass
//   dispatch_rdy        in   Dispatch takes the output group
//   renamed_insts       out  renamed group
// The master modport is the mirror image, used by the surrounding pipeline.

package rename_nway_pkg;
    parameter int unsigned TAG_WIDTH = 6;
    parameter int unsigned XLEN      = 32;

    localparam logic [6:0] OPC_LUI = 7'b0110111;

    typedef struct packed {
        logic [XLEN-1:0]      data;
        logic [TAG_WIDTH-1:0] tag;
        logic                 is_renamed;
    } source_t;

    typedef struct packed {
        logic                 is_valid;
        logic [31:0]          pc;
        logic [6:0]           opcode;
        logic [6:0]           funct7;
        logic [4:0]           rd;
        logic                 has_rd;
        logic                 br_taken;
        logic [7:0]           uop_0;
        logic [7:0]           uop_1;
        source_t              src_0_a;
        source_t              src_0_b;
        source_t              src_1_a;
        source_t              src_1_b;
        logic [TAG_WIDTH-1:0] dest_tag;
    } instruction_t;

    typedef struct packed {
        logic                 we;
        logic [4:0]           addr;
        logic [TAG_WIDTH-1:0] tag;
    } prf_rat_write_port_t;

    typedef struct packed {
        logic                 we;
        logic [TAG_WIDTH-1:0] tag;
        logic [XLEN-1:0]      data;
    } prf_commit_write_port_t;
endpackage

interface rename_nway_if #(
    parameter int unsigned W = 4,
    parameter int unsigned C = 2
);
    import rename_nway_pkg::*;

    logic                                 flush;
    instruction_t [W-1:0]                 decoded_insts;
    logic [W-1:0]                         dec_accept;
    logic [W-1:0][4:0]                    rat_rs1_addr;
    logic [W-1:0][4:0]                    rat_rs2_addr;
    source_t [W-1:0]                      rat_rs1_data;
    source_t [W-1:0]                      rat_rs2_data;
    prf_rat_write_port_t [W-1:0]          rat_write_ports;
    logic [W-1:0]                         rob_alloc_req;
    logic [W-1:0]                         rob_alloc_gnt;
    logic [W-1:0][TAG_WIDTH-1:0]          rob_alloc_tags;
    prf_commit_write_port_t [C-1:0]       commit_write_ports;
    logic                                 dispatch_rdy;
    instruction_t [W-1:0]                 renamed_insts;

    modport slave (
        input  flush, decoded_insts, rat_rs1_data, rat_rs2_data, rob_alloc_gnt,
               rob_alloc_tags, commit_write_ports, dispatch_rdy,
        output dec_accept, rat_rs1_addr, rat_rs2_addr, rat_write_ports, rob_alloc_req,
               renamed_insts
    );

    modport master (
        output flush, decoded_insts, rat_rs1_data, rat_rs2_data, rob_alloc_gnt,
               rob_alloc_tags, commit_write_ports, dispatch_rdy,
        input  dec_accept, rat_rs1_addr, rat_rs2_addr, rat_write_ports, rob_alloc_req,
               renamed_insts
    );
endinterface

// File: rtl/rename_nway.sv
// rename_nway
//
// Purpose: W-wide register-rename stage between Decode and Dispatch. Allocates
// ROB tags, reads/writes the RAT, forwards intra-group dependencies and applies
// commit bypass both at rename time and to a group held by a dispatch stall.
//
// Ports:
//   clk    in  clock
//   rst_n  in  asynchronous active-low reset
//   bus    rename_nway_if.slave, all decode/RAT/ROB/commit/dispatch signals

module rename_nway
    import rename_nway_pkg::*;
#(
    parameter int unsigned W = 4,
    parameter int unsigned C = 2
) (
    input logic         clk,
    input logic         rst_n,
    rename_nway_if.slave bus
);

    instruction_t [W-1:0] grp_q, grp_d;
    instruction_t [W-1:0] new_grp;
    instruction_t [W-1:0] held;
    logic [W-1:0]         valid_in;
    logic [W-1:0]         req;
    logic [W-1:0]         acc;
    logic                 load_en;
    logic                 chain;

    // Lowest-numbered matching commit port wins.
    function automatic source_t commit_bypass(source_t s, prf_commit_write_port_t [C-1:0] cp);
        source_t r;
        logic    hit;
        r   = s;
        hit = 1'b0;
        for (int unsigned c = 0; c < C; c++) begin
            if (!hit && s.is_renamed && cp[c].we && (cp[c].tag == s.tag)) begin
                r.data       = cp[c].data;
                r.tag        = '0;
                r.is_renamed = 1'b0;
                hit          = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic instruction_t bypass_inst(instruction_t in,
                                                 prf_commit_write_port_t [C-1:0] cp);
        instruction_t r;
        r         = in;
        r.src_0_a = commit_bypass(in.src_0_a, cp);
        r.src_0_b = commit_bypass(in.src_0_b, cp);
        r.src_1_a = commit_bypass(in.src_1_a, cp);
        r.src_1_b = commit_bypass(in.src_1_b, cp);
        return r;
    endfunction

    // x0 -> zero; else youngest older accepted writer of rs; else RAT + commit bypass.
    function automatic source_t rename_src(int unsigned slot, logic [4:0] rs, source_t rat_val,
                                           logic [W-1:0] acc_m, instruction_t [W-1:0] dec,
                                           logic [W-1:0][TAG_WIDTH-1:0] tags,
                                           prf_commit_write_port_t [C-1:0] cp);
        source_t r;
        logic    fwd;
        r   = '0;
        fwd = 1'b0;
        if (rs != 5'd0) begin
            for (int unsigned j = 0; j < W; j++) begin
                if ((j < slot) && acc_m[j] && dec[j].has_rd && (dec[j].rd == rs)) begin
                    fwd          = 1'b1;
                    r.data       = '0;
                    r.tag        = tags[j];
                    r.is_renamed = 1'b1;
                end
            end
            if (!fwd) begin
                r = commit_bypass(rat_val, cp);
            end
        end
        return r;
    endfunction

    // A younger accepted slot writing the same rd makes this slot's RAT write redundant.
    function automatic logic younger_writer(int unsigned slot, logic [W-1:0] acc_m,
                                            instruction_t [W-1:0] dec);
        logic hit;
        hit = 1'b0;
        for (int unsigned k = 0; k < W; k++) begin
            if ((k > slot) && acc_m[k] && dec[k].has_rd && (dec[k].rd == dec[slot].rd)) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    function automatic logic is_prefix(logic [W-1:0] m);
        return (m & (m + W'(1))) == '0;
    endfunction

    always_comb begin
        load_en = rst_n && !bus.flush && (!grp_q[0].is_valid || bus.dispatch_rdy);
        chain   = 1'b1;
        for (int unsigned i = 0; i < W; i++) begin
            valid_in[i] = bus.decoded_insts[i].is_valid;
            req[i]      = load_en && valid_in[i];
            acc[i]      = req[i] && bus.rob_alloc_gnt[i] && chain;
            chain       = acc[i];
        end

        for (int unsigned i = 0; i < W; i++) begin
            held[i]    = bypass_inst(grp_q[i], bus.commit_write_ports);
            new_grp[i] = '0;
            if (acc[i]) begin
                new_grp[i].is_valid = 1'b1;
                new_grp[i].pc       = bus.decoded_insts[i].pc;
                new_grp[i].opcode   = bus.decoded_insts[i].opcode;
                new_grp[i].funct7   = bus.decoded_insts[i].funct7;
                new_grp[i].rd       = bus.decoded_insts[i].rd;
                new_grp[i].has_rd   = bus.decoded_insts[i].has_rd;
                new_grp[i].br_taken = bus.decoded_insts[i].br_taken;
                new_grp[i].uop_0    = bus.decoded_insts[i].uop_0;
                new_grp[i].uop_1    = bus.decoded_insts[i].uop_1;
                new_grp[i].dest_tag = bus.rob_alloc_tags[i];
                new_grp[i].src_1_a  = rename_src(i, bus.decoded_insts[i].src_1_a.tag[4:0],
                                                 bus.rat_rs1_data[i], acc, bus.decoded_insts,
                                                 bus.rob_alloc_tags, bus.commit_write_ports);
                new_grp[i].src_1_b  = rename_src(i, bus.decoded_insts[i].src_1_b.tag[4:0],
                                                 bus.rat_rs2_data[i], acc, bus.decoded_insts,
                                                 bus.rob_alloc_tags, bus.commit_write_ports);
                // src_0_x mirror src_1_x only when decode tagged them as the same operand.
                if ((bus.decoded_insts[i].src_0_a.tag == bus.decoded_insts[i].src_1_a.tag) &&
                    (bus.decoded_insts[i].opcode != OPC_LUI)) begin
                    new_grp[i].src_0_a = new_grp[i].src_1_a;
                end else begin
                    new_grp[i].src_0_a.data = bus.decoded_insts[i].src_0_a.data;
                end
                if (bus.decoded_insts[i].src_0_b.tag == bus.decoded_insts[i].src_1_b.tag) begin
                    new_grp[i].src_0_b = new_grp[i].src_1_b;
                end else begin
                    new_grp[i].src_0_b.data = bus.decoded_insts[i].src_0_b.data;
                end
            end
        end

        if (bus.flush) begin
            grp_d = '0;
        end else if (load_en) begin
            grp_d = new_grp;
        end else begin
            grp_d = held;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grp_q <= '0;
        end else begin
            grp_q <= grp_d;
        end
    end

    always_comb begin
        bus.dec_accept    = acc;
        bus.rob_alloc_req = req;
        bus.renamed_insts = rst_n ? held : '0;
        for (int unsigned i = 0; i < W; i++) begin
            bus.rat_rs1_addr[i]    = '0;
            bus.rat_rs2_addr[i]    = '0;
            bus.rat_write_ports[i] = '0;
            if (rst_n) begin
                bus.rat_rs1_addr[i]         = bus.decoded_insts[i].src_1_a.tag[4:0];
                bus.rat_rs2_addr[i]         = bus.decoded_insts[i].src_1_b.tag[4:0];
                bus.rat_write_ports[i].addr = bus.decoded_insts[i].rd;
                bus.rat_write_ports[i].tag  = bus.rob_alloc_tags[i];
                bus.rat_write_ports[i].we   = acc[i] && bus.decoded_insts[i].has_rd &&
                                              (bus.decoded_insts[i].rd != 5'd0) &&
                                              !younger_writer(i, acc, bus.decoded_insts);
            end
        end
    end

    a_valid_prefix: assert property (@(posedge clk) disable iff (!rst_n) is_prefix(valid_in));
    a_gnt_prefix: assert property (@(posedge clk) disable iff (!rst_n)
                                   is_prefix(bus.rob_alloc_gnt));
    a_gnt_in_req: assert property (@(posedge clk) disable iff (!rst_n)
                                   (bus.rob_alloc_gnt & ~bus.rob_alloc_req) == '0);

endmodule

// File: tb/tb_rename_nway.sv
module tb_rename_nway;
    import rename_nway_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [3:0] gnt_mask;
    logic [3:0] rat_we;
    logic [3:0] out_valid;
    source_t    rat_mem [32];
    int         n_checks;
    int         n_fail;

    rename_nway_if #(.W(4), .C(2)) bus ();

    rename_nway #(.W(4), .C(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.rob_alloc_gnt = gnt_mask & bus.rob_alloc_req;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            bus.rat_rs1_data[i] = rat_mem[bus.rat_rs1_addr[i]];
            bus.rat_rs2_data[i] = rat_mem[bus.rat_rs2_addr[i]];
            rat_we[i]           = bus.rat_write_ports[i].we;
            out_valid[i]        = bus.renamed_insts[i].is_valid;
        end
    end

    function automatic source_t src(logic [31:0] data, logic [TAG_WIDTH-1:0] tag, logic ren);
        source_t s;
        s.data       = data;
        s.tag        = tag;
        s.is_renamed = ren;
        return s;
    endfunction

    function automatic instruction_t mk(logic [31:0] pc, logic [4:0] rd, logic [4:0] rs1,
                                        logic [4:0] rs2);
        instruction_t t;
        t              = '0;
        t.is_valid     = 1'b1;
        t.pc           = pc;
        t.opcode       = 7'h33;
        t.rd           = rd;
        t.has_rd       = 1'b1;
        t.src_1_a.tag  = TAG_WIDTH'(rs1);
        t.src_1_b.tag  = TAG_WIDTH'(rs2);
        t.src_0_a.tag  = '1;
        t.src_0_a.data = 32'hA0;
        t.src_0_b.tag  = '1;
        t.src_0_b.data = 32'hB0;
        return t;
    endfunction

    task automatic rat_default();
        for (int r = 0; r < 32; r++) rat_mem[r] = src(32'h100 + r, '0, 1'b0);
    endtask

    task automatic idle();
        for (int i = 0; i < 4; i++) begin
            bus.decoded_insts[i]  = '0;
            bus.rob_alloc_tags[i] = '0;
        end
        bus.commit_write_ports = '0;
        bus.flush              = 1'b0;
        bus.dispatch_rdy       = 1'b1;
        gnt_mask               = 4'b0000;
    endtask

    // Empties the output register with Dispatch ready.
    task automatic drain();
        idle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        @(negedge clk);
        bus.decoded_insts[0] = mk(32'h10, 5'd1, 5'd2, 5'd3);
        gnt_mask = 4'b1111;
        #1;
        n_checks++;
        if (bus.rob_alloc_req !== 4'b0000) begin
            n_fail++; $display("FAIL reset_req: got %b want 0000", bus.rob_alloc_req);
        end
        n_checks++;
        if (bus.dec_accept !== 4'b0000) begin
            n_fail++; $display("FAIL reset_accept: got %b want 0000", bus.dec_accept);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.renamed_insts !== '0) begin
            n_fail++; $display("FAIL reset_out: got %h want 0", bus.renamed_insts);
        end
        @(negedge clk);
        idle();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 4'b0000) begin
            n_fail++; $display("FAIL reset_release_valid: got %b want 0000", out_valid);
        end
    endtask

    task automatic test_indep();
        drain();
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            bus.decoded_insts[i]  = mk(32'h1000 + 4 * i, 5'(10 + i), 5'd1, 5'd2);
            bus.rob_alloc_tags[i] = TAG_WIDTH'(8 + i);
        end
        gnt_mask = 4'b1111;
        #1;
        n_checks++;
        if (bus.dec_accept !== 4'b1111) begin
            n_fail++; $display("FAIL t1_accept: got %b want 1111", bus.dec_accept);
        end
        n_checks++;
        if (rat_we !== 4'b1111) begin
            n_fail++; $display("FAIL t1_rat_we: got %b want 1111", rat_we);
        end
        n_checks++;
        if (bus.rat_write_ports[3].addr !== 5'd13 || bus.rat_write_ports[3].tag !== 6'd11) begin
            n_fail++; $display("FAIL t1_rat_port3: got addr %0d tag %0d want 13 11",
                               bus.rat_write_ports[3].addr, bus.rat_write_ports[3].tag);
        end
        @(posedge clk);
        #1;
        idle();
        n_checks++;
        if (out_valid !== 4'b1111) begin
            n_fail++; $display("FAIL t1_valid: got %b want 1111", out_valid);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (bus.renamed_insts[i].dest_tag !== TAG_WIDTH'(8 + i)) begin
                n_fail++; $display("FAIL t1_dest_tag%0d: got %0d want %0d", i,
                                   bus.renamed_insts[i].dest_tag, 8 + i);
            end
        end
        n_checks++;
        if (bus.renamed_insts[2].src_1_a !== src(32'h101, '0, 1'b0)) begin
            n_fail++; $display("FAIL t1_rat_src: got %h want %h", bus.renamed_insts[2].src_1_a,
                               src(32'h101, '0, 1'b0));
        end
        n_checks++;
        if (bus.renamed_insts[0].src_0_a !== src(32'hA0, '0, 1'b0) ||
            bus.renamed_insts[0].pc !== 32'h1000) begin
            n_fail++; $display("FAIL t1_passthru: got %h pc %h want A0 1000",
                               bus.renamed_insts[0].src_0_a, bus.renamed_insts[0].pc);
        end
    endtask

    task automatic test_forward();
        drain();
        @(negedge clk);
        bus.decoded_insts[0] = mk(32'h1100, 5'd5, 5'd1, 5'd2);
        bus.decoded_insts[1] = mk(32'h1104, 5'd6, 5'd5, 5'd2);
        bus.decoded_insts[2] = mk(32'h1108, 5'd5, 5'd3, 5'd4);
        bus.decoded_insts[3] = mk(32'h110C, 5'd7, 5'd5, 5'd0);
        for (int i = 0; i < 4; i++) bus.rob_alloc_tags[i] = TAG_WIDTH'(12 + i);
        gnt_mask = 4'b1111;
        #1;
        n_checks++;
        if (rat_we !== 4'b1110) begin
            n_fail++; $display("FAIL t2_rat_we: got %b want 1110", rat_we);
        end
        @(posedge clk);
        #1;
        idle();
        n_checks++;
        if (bus.renamed_insts[3].src_1_a !== src('0, 6'd14, 1'b1)) begin
            n_fail++; $display("FAIL t2_fwd_youngest: got %h want %h",
                               bus.renamed_insts[3].src_1_a, src('0, 6'd14, 1'b1));
        end
        n_checks++;
        if (bus.renamed_insts[1].src_1_a !== src('0, 6'd12, 1'b1)) begin
            n_fail++; $display("FAIL t2_fwd_s1: got %h want %h",
                               bus.renamed_insts[1].src_1_a, src('0, 6'd12, 1'b1));
        end
        n_checks++;
        if (bus.renamed_insts[2].src_1_a !== src(32'h103, '0, 1'b0)) begin
            n_fail++; $display("FAIL t2_no_fwd: got %h want %h",
                               bus.renamed_insts[2].src_1_a, src(32'h103, '0, 1'b0));
        end
    endtask

    task automatic test_partial();
        drain();
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            bus.decoded_insts[i]  = mk(32'h2000 + 4 * i, 5'(20 + i), 5'd1, 5'd2);
            bus.rob_alloc_tags[i] = TAG_WIDTH'(16 + i);
        end
        gnt_mask = 4'b0011;
        #1;
        n_checks++;
        if (bus.dec_accept !== 4'b0011) begin
            n_fail++; $display("FAIL t3_accept: got %b want 0011", bus.dec_accept);
        end
        n_checks++;
        if (rat_we !== 4'b0011) begin
            n_fail++; $display("FAIL t3_rat_we: got %b want 0011", rat_we);
        end
        @(posedge clk);
        #1;
        bus.decoded_insts[0]  = mk(32'h2008, 5'd22, 5'd1, 5'd2);
        bus.decoded_insts[1]  = mk(32'h200C, 5'd23, 5'd1, 5'd2);
        bus.decoded_insts[2]  = '0;
        bus.decoded_insts[3]  = '0;
        bus.rob_alloc_tags[0] = 6'd24;
        bus.rob_alloc_tags[1] = 6'd25;
        gnt_mask = 4'b1111;
        n_checks++;
        if (out_valid !== 4'b0011 || bus.renamed_insts[1].dest_tag !== 6'd17) begin
            n_fail++; $display("FAIL t3_first_out: got valid %b tag %0d want 0011 17",
                               out_valid, bus.renamed_insts[1].dest_tag);
        end
        @(posedge clk);
        #1;
        idle();
        n_checks++;
        if (out_valid !== 4'b0011 || bus.renamed_insts[0].dest_tag !== 6'd24 ||
            bus.renamed_insts[0].pc !== 32'h2008 || bus.renamed_insts[1].rd !== 5'd23) begin
            n_fail++; $display("FAIL t3_remainder: got valid %b tag %0d pc %h rd %0d want 0011 24 2008 23",
                               out_valid, bus.renamed_insts[0].dest_tag,
                               bus.renamed_insts[0].pc, bus.renamed_insts[1].rd);
        end
    endtask

    task automatic test_hold_bypass();
        drain();
        rat_mem[9] = src('0, 6'd7, 1'b1);
        @(negedge clk);
        bus.decoded_insts[0]  = mk(32'h3000, 5'd12, 5'd1, 5'd2);
        bus.decoded_insts[1]  = mk(32'h3004, 5'd13, 5'd1, 5'd9);
        bus.rob_alloc_tags[0] = 6'd30;
        bus.rob_alloc_tags[1] = 6'd31;
        gnt_mask = 4'b0011;
        bus.dispatch_rdy = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.rob_alloc_req !== 4'b0000 || bus.dec_accept !== 4'b0000 || rat_we !== 4'b0000) begin
            n_fail++; $display("FAIL t4_hold_idle: got req %b acc %b we %b want 0000",
                               bus.rob_alloc_req, bus.dec_accept, rat_we);
        end
        n_checks++;
        if (bus.renamed_insts[1].src_1_b !== src('0, 6'd7, 1'b1)) begin
            n_fail++; $display("FAIL t4_pre_commit: got %h want %h",
                               bus.renamed_insts[1].src_1_b, src('0, 6'd7, 1'b1));
        end
        @(negedge clk);
        bus.commit_write_ports[1].we   = 1'b1;
        bus.commit_write_ports[1].tag  = 6'd7;
        bus.commit_write_ports[1].data = 32'hDEAD;
        #1;
        n_checks++;
        if (bus.renamed_insts[1].src_1_b !== src(32'hDEAD, '0, 1'b0)) begin
            n_fail++; $display("FAIL t4_same_cycle: got %h want %h",
                               bus.renamed_insts[1].src_1_b, src(32'hDEAD, '0, 1'b0));
        end
        @(posedge clk);
        #1;
        bus.commit_write_ports = '0;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (bus.renamed_insts[1].src_1_b !== src(32'hDEAD, '0, 1'b0) || out_valid !== 4'b0011) begin
                n_fail++; $display("FAIL t4_held_%0d: got %h valid %b want %h 0011", k,
                                   bus.renamed_insts[1].src_1_b, out_valid, src(32'hDEAD, '0, 1'b0));
            end
            @(posedge clk);
            #1;
        end
        rat_default();
    endtask

    task automatic test_commit_bypass();
        drain();
        rat_mem[3] = src('0, 6'd3, 1'b1);
        @(negedge clk);
        bus.decoded_insts[0]  = mk(32'h4000, 5'd14, 5'd3, 5'd0);
        bus.decoded_insts[1]  = mk(32'h4004, 5'd15, 5'd1, 5'd2);
        bus.decoded_insts[1].src_0_a.tag = 6'd1;
        bus.rob_alloc_tags[0] = 6'd40;
        bus.rob_alloc_tags[1] = 6'd41;
        gnt_mask = 4'b0011;
        bus.commit_write_ports[0] = '{we: 1'b1, tag: 6'd3, data: 32'h42};
        bus.commit_write_ports[1] = '{we: 1'b1, tag: 6'd3, data: 32'h99};
        @(posedge clk);
        #1;
        idle();
        n_checks++;
        if (bus.renamed_insts[0].src_1_a !== src(32'h42, '0, 1'b0)) begin
            n_fail++; $display("FAIL t5_bypass: got %h want %h",
                               bus.renamed_insts[0].src_1_a, src(32'h42, '0, 1'b0));
        end
        n_checks++;
        if (bus.renamed_insts[0].src_1_b !== src('0, '0, 1'b0)) begin
            n_fail++; $display("FAIL t5_x0: got %h want 0", bus.renamed_insts[0].src_1_b);
        end
        n_checks++;
        if (bus.renamed_insts[1].src_0_a !== src(32'h101, '0, 1'b0)) begin
            n_fail++; $display("FAIL t5_src0_copy: got %h want %h",
                               bus.renamed_insts[1].src_0_a, src(32'h101, '0, 1'b0));
        end
        rat_default();
    endtask

    task automatic test_flush_reset();
        drain();
        @(negedge clk);
        bus.decoded_insts[0]  = mk(32'h5000, 5'd15, 5'd1, 5'd2);
        bus.rob_alloc_tags[0] = 6'd50;
        gnt_mask = 4'b1111;
        bus.dispatch_rdy = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        bus.flush = 1'b1;
        bus.dispatch_rdy = 1'b1;
        #1;
        n_checks++;
        if (bus.rob_alloc_req !== 4'b0000 || bus.dec_accept !== 4'b0000 || rat_we !== 4'b0000) begin
            n_fail++; $display("FAIL t6_flush_comb: got req %b acc %b we %b want 0000",
                               bus.rob_alloc_req, bus.dec_accept, rat_we);
        end
        @(posedge clk);
        #1;
        idle();
        n_checks++;
        if (bus.renamed_insts !== '0) begin
            n_fail++; $display("FAIL t6_flush_out: got %h want 0", bus.renamed_insts);
        end
        @(negedge clk);
        bus.decoded_insts[0]  = mk(32'h5100, 5'd16, 5'd1, 5'd2);
        bus.rob_alloc_tags[0] = 6'd51;
        gnt_mask = 4'b1111;
        bus.dispatch_rdy = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 4'b0001) begin
            n_fail++; $display("FAIL t6_loaded: got %b want 0001", out_valid);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.renamed_insts !== '0 || bus.dec_accept !== 4'b0000) begin
            n_fail++; $display("FAIL t6_async_reset: got %h acc %b want 0",
                               bus.renamed_insts, bus.dec_accept);
        end
        @(negedge clk);
        idle();
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rat_default();
        test_reset();
        test_indep();
        test_forward();
        test_partial();
        test_hold_bypass();
        test_commit_bypass();
        test_flush_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
